// File: rtl/obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_spawner
// Brief    : Counts a random tick gap, then offers one obstacle spawn request
//            (type + variant) downstream over valid/ready. Optional macro
//            GAP_SPEEDUP_EN shrinks the random gap with the speed level.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_spawner #(
    parameter int MIN_GAP  = 20,
    parameter int GAP_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  tick,
    input  logic [29:0]           rnd,
    input  logic                  bird_en,
    input  logic [2:0]            level,
    output logic                  spawn_valid,
    input  logic                  spawn_ready,
    output logic [1:0]            obj_type,
    output logic [1:0]            obj_var,
    output logic [GAP_BITS+7:0]   gap_left,
    output logic [CNT_W-1:0]      spawn_count
);

    localparam int GW = GAP_BITS + 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WAIT  = 2'd2,
        S_OFFER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [1:0]         type_q,  type_d;
    logic [1:0]         var_q,   var_d;
    logic [GW-1:0]      gap_q,   gap_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [GAP_BITS-1:0] w_rnd_low;
    logic [GAP_BITS-1:0] w_extra;
    logic [GW-1:0]       w_load_gap;
    logic [1:0]          w_raw_type;
    logic [1:0]          w_type;
    logic [1:0]          w_var;
    logic                w_accept;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_unused;

    assign w_rnd_low = rnd[GAP_BITS-1:0];

`ifdef GAP_SPEEDUP_EN
    logic [4:0] w_shamt;
    // Shift is clamped so a high level floors the gap at MIN_GAP
    assign w_shamt  = ({2'b00, level} > 5'(GAP_BITS)) ? 5'(GAP_BITS) : {2'b00, level};
    assign w_extra  = w_rnd_low >> w_shamt;
    assign w_unused = ^rnd;
`else
    assign w_extra  = w_rnd_low;
    assign w_unused = ^{rnd, level};
`endif

    assign w_load_gap  = GW'(MIN_GAP) + GW'(w_extra);
    assign w_raw_type  = rnd[29:28];
    assign w_type      = ((w_raw_type == 2'd3) && !bird_en) ? 2'd0 : w_raw_type;
    assign w_var       = (w_type != 2'd3)       ? 2'd0 :
                         (rnd[27:26] == 2'd3)   ? 2'd0 : rnd[27:26];
    assign w_accept    = (state_q == S_OFFER) && valid_q && spawn_ready;
    assign w_count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        type_d  = type_q;
        var_d   = var_q;
        gap_d   = gap_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                type_d  = 2'd0;
                var_d   = 2'd0;
                gap_d   = '0;
                if (run) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                gap_d   = w_load_gap;
                type_d  = w_type;
                var_d   = w_var;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick) begin
                    if (gap_q > GW'(1)) begin
                        gap_d = gap_q - GW'(1);
                    end else begin
                        gap_d   = '0;
                        valid_d = 1'b1;
                        state_d = S_OFFER;
                    end
                end
            end
            S_OFFER: begin
                if (w_accept) begin
                    valid_d = 1'b0;
                    count_d = w_count_inc;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Leaving the running state wins over everything except a same-cycle transfer count
        if (!run) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            gap_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            type_q  <= 2'd0;
            var_q   <= 2'd0;
            gap_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            var_q   <= var_d;
            gap_q   <= gap_d;
            count_q <= count_d;
        end
    end

    assign spawn_valid = valid_q;
    assign obj_type    = type_q;
    assign obj_var     = var_q;
    assign gap_left    = gap_q;
    assign spawn_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_spawner
// Brief    : Directed self-checking bench for obstacle_spawner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_spawner;

`ifdef GAP_SPEEDUP_EN
    localparam int EXP_LVL_GAP = 25;
`else
    localparam int EXP_LVL_GAP = 61;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, tick, bird_en, spawn_ready;
    logic [29:0] rnd;
    logic [2:0]  level;
    logic        spawn_valid;
    logic [1:0]  obj_type, obj_var;
    logic [13:0] gap_left;
    logic [15:0] spawn_count;

    // Small-counter instance to reach saturation quickly
    logic        run2, tick2, ready2;
    logic        valid2;
    logic [1:0]  type2, var2;
    logic [8:0]  gap2;
    logic [1:0]  count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obstacle_spawner #(.MIN_GAP(20), .GAP_BITS(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .tick(tick), .rnd(rnd),
        .bird_en(bird_en), .level(level), .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready), .obj_type(obj_type), .obj_var(obj_var),
        .gap_left(gap_left), .spawn_count(spawn_count)
    );

    obstacle_spawner #(.MIN_GAP(1), .GAP_BITS(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .tick(tick2), .rnd(30'h0),
        .bird_en(1'b0), .level(3'd0), .spawn_valid(valid2),
        .spawn_ready(ready2), .obj_type(type2), .obj_var(var2),
        .gap_left(gap2), .spawn_count(count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic accept();
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; tick = 1'b0; bird_en = 1'b0;
        spawn_ready = 1'b0; rnd = 30'h0; level = 3'd0;
        run2 = 1'b0; tick2 = 1'b0; ready2 = 1'b0;

        #12;
        check("rst_valid", 32'(spawn_valid), 0);
        check("rst_type",  32'(obj_type),    0);
        check("rst_var",   32'(obj_var),     0);
        check("rst_gap",   32'(gap_left),    0);
        check("rst_count", 32'(spawn_count), 0);
        rst_n = 1'b1;
        step();

        // First load: type 2, gap 20+41
        rnd = 30'h20000029; run = 1'b1;
        step();
        step();
        check("load1_gap",   32'(gap_left),    61);
        check("load1_type",  32'(obj_type),    2);
        check("load1_var",   32'(obj_var),     0);
        check("load1_valid", 32'(spawn_valid), 0);
        check("load1_count", 32'(spawn_count), 0);

        do_ticks(60);
        check("t60_gap",   32'(gap_left),    1);
        check("t60_valid", 32'(spawn_valid), 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("t61_valid", 32'(spawn_valid), 1);
        check("t61_gap",   32'(gap_left),    0);

        // Stall in OFFER with ticks arriving
        for (int i = 0; i < 100; i++) begin
            tick = (i % 10 == 0);
            step();
            check("stall_valid", 32'(spawn_valid), 1);
            check("stall_type",  32'(obj_type),    2);
            check("stall_gap",   32'(gap_left),    0);
            check("stall_count", 32'(spawn_count), 0);
        end
        tick = 1'b0;

        rnd = 30'h3C000000; bird_en = 1'b0;
        accept();
        check("acc1_count", 32'(spawn_count), 1);
        check("acc1_valid", 32'(spawn_valid), 0);
        step();
        check("nobird_type", 32'(obj_type), 0);
        check("nobird_var",  32'(obj_var),  0);
        check("nobird_gap",  32'(gap_left), 20);

        do_ticks(20);
        check("off2_valid", 32'(spawn_valid), 1);
        bird_en = 1'b1;
        accept();
        step();
        check("bird3_type",  32'(obj_type),    3);
        check("bird3_var",   32'(obj_var),     0);
        check("bird3_count", 32'(spawn_count), 2);

        do_ticks(20);
        rnd = 30'h38000000;
        accept();
        step();
        check("bird2_type",  32'(obj_type),    3);
        check("bird2_var",   32'(obj_var),     2);
        check("bird2_count", 32'(spawn_count), 3);

        do_ticks(20);
        rnd = 30'h0000000A; bird_en = 1'b0;
        accept();
        step();
        check("gap30", 32'(gap_left), 30);

        // Drop run mid-WAIT
        run = 1'b0;
        step();
        check("stop_gap",   32'(gap_left),    0);
        check("stop_valid", 32'(spawn_valid), 0);
        check("stop_count", 32'(spawn_count), 4);
        step();
        check("idle_count", 32'(spawn_count), 4);
        check("idle_type",  32'(obj_type),    0);

        // Restart with level 3
        rnd = 30'h20000029; level = 3'd3; run = 1'b1;
        step();
        check("restart_count", 32'(spawn_count), 0);
        step();
        check("level_gap", 32'(gap_left), EXP_LVL_GAP);

        do_ticks(EXP_LVL_GAP - 1);
        check("lvl_pre_valid", 32'(spawn_valid), 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("lvl_valid", 32'(spawn_valid), 1);

        // run falls in the same cycle as a transfer
        run = 1'b0; spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0; level = 3'd0;
        check("stopacc_valid", 32'(spawn_valid), 0);
        check("stopacc_gap",   32'(gap_left),    0);
        check("stopacc_count", 32'(spawn_count), 1);

        // Async reset between clock edges
        run = 1'b1;
        step();
        step();
        check("pre_arst_gap", 32'(gap_left), 61);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gap",   32'(gap_left),    0);
        check("arst_type",  32'(obj_type),    0);
        check("arst_valid", 32'(spawn_valid), 0);
        run = 1'b0;
        rst_n = 1'b1;
        step();

        // Saturation on a 2-bit counter
        run2 = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            step();
            tick2 = 1'b1;
            step();
            tick2 = 1'b0;
            check("sat_valid", 32'(valid2), 1);
            ready2 = 1'b1;
            step();
            ready2 = 1'b0;
            check("sat_count", 32'(count2), (k > 3) ? 3 : k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
